// File: rtl/vend_change_ctrl.sv
// rtl/vend_change_ctrl.sv - vending transaction controller with greedy change payout
//
// Purpose: collects coins toward a latched price, pulses soda once the registered
// total reaches the price, then pays out change one coin at a time (25/10/5/1c)
// through a req/ack hopper handshake.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, price             begin a transaction (IDLE only), price in cents
//   coin_valid, coin_value   presented coin; accepted when coin_ready is high
//   coin_ready               high only in COLLECT
//   cancel                   refund request in COLLECT (VEND_CANCEL_EN builds only)
//   soda                     one-cycle dispense pulse
//   total                    registered running coin total (saturating)
//   hopper_req, hopper_coin  change-coin request, denomination 0=1c 1=5c 2=10c 3=25c
//   hopper_ack               hopper has paid the requested coin
//   busy, done               not-IDLE flag, one-cycle completion pulse
//
// Optional feature macro: VEND_CANCEL_EN enables the cancel/refund path.

module vend_change_ctrl #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] price,
   input  logic         coin_valid,
   input  logic [W-1:0] coin_value,
   output logic         coin_ready,
   input  logic         cancel,
   output logic         soda,
   output logic [W-1:0] total,
   output logic         hopper_req,
   output logic [1:0]   hopper_coin,
   input  logic         hopper_ack,
   output logic         busy,
   output logic         done
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_COLLECT  = 3'd1,
      ST_VEND     = 3'd2,
      ST_PAYOUT   = 3'd3,
      ST_WAIT_ACK = 3'd4,
      ST_DONE     = 3'd5
   } state_t;

   state_t       state_q, state_d;
   logic [W-1:0] price_q, price_d;
   logic [W-1:0] total_q, total_d;
   logic [W-1:0] change_q, change_d;
   logic         hopper_req_q, hopper_req_d;
   logic [1:0]   hopper_coin_q, hopper_coin_d;
   logic         coin_ready_q, coin_ready_d;
   logic         soda_q, soda_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;

   logic [W:0]   coin_sum;
   logic [W-1:0] total_acc;
   logic         coin_acc;

   // Largest denomination code not exceeding the remaining change.
   function automatic logic [1:0] pick_denom(input logic [W-1:0] c);
      if (32'(c) >= 32'd25)      return 2'd3;
      else if (32'(c) >= 32'd10) return 2'd2;
      else if (32'(c) >= 32'd5)  return 2'd1;
      else                       return 2'd0;
   endfunction

   function automatic logic [W-1:0] denom_value(input logic [1:0] d);
      case (d)
         2'd3:    return W'(25);
         2'd2:    return W'(10);
         2'd1:    return W'(5);
         default: return W'(1);
      endcase
   endfunction

   // Extra carry bit detects overflow so the total can clamp at all-ones.
   assign coin_sum  = {1'b0, total_q} + {1'b0, coin_value};
   assign total_acc = coin_sum[W] ? {W{1'b1}} : coin_sum[W-1:0];
   assign coin_acc  = coin_valid && coin_ready_q;

`ifndef VEND_CANCEL_EN
   logic unused_cancel;
   assign unused_cancel = cancel;
`endif

   always_comb begin
      state_d       = state_q;
      price_d       = price_q;
      total_d       = total_q;
      change_d      = change_q;
      hopper_req_d  = hopper_req_q;
      hopper_coin_d = hopper_coin_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               price_d = price;
               total_d = '0;
               state_d = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            if (coin_acc) total_d = total_acc;
`ifdef VEND_CANCEL_EN
            // Cancel wins over vending; a coin taken this same edge is refunded too.
            if (cancel) begin
               change_d = coin_acc ? total_acc : total_q;
               state_d  = ST_PAYOUT;
            end else if (total_q >= price_q) begin
               state_d = ST_VEND;
            end
`else
            // Compare the registered total so a coin vends one edge after acceptance.
            if (total_q >= price_q) state_d = ST_VEND;
`endif
         end
         ST_VEND: begin
            change_d = total_q - price_q;
            state_d  = ST_PAYOUT;
         end
         ST_PAYOUT: begin
            if (change_q == '0) begin
               state_d = ST_DONE;
            end else begin
               hopper_coin_d = pick_denom(change_q);
               hopper_req_d  = 1'b1;
               state_d       = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            if (hopper_ack) begin
               change_d     = change_q - denom_value(hopper_coin_q);
               hopper_req_d = 1'b0;
               state_d      = ST_PAYOUT;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            hopper_req_d = 1'b0;
            state_d      = ST_IDLE;
         end
      endcase

      // Status outputs are registered copies of the next state's decode.
      coin_ready_d = (state_d == ST_COLLECT);
      soda_d       = (state_d == ST_VEND);
      busy_d       = (state_d != ST_IDLE);
      done_d       = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         price_q       <= '0;
         total_q       <= '0;
         change_q      <= '0;
         hopper_req_q  <= 1'b0;
         hopper_coin_q <= 2'd0;
         coin_ready_q  <= 1'b0;
         soda_q        <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         price_q       <= price_d;
         total_q       <= total_d;
         change_q      <= change_d;
         hopper_req_q  <= hopper_req_d;
         hopper_coin_q <= hopper_coin_d;
         coin_ready_q  <= coin_ready_d;
         soda_q        <= soda_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign coin_ready  = coin_ready_q;
   assign soda        = soda_q;
   assign total       = total_q;
   assign hopper_req  = hopper_req_q;
   assign hopper_coin = hopper_coin_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_vend_change_ctrl.sv
// tb/tb_vend_change_ctrl.sv - directed self-checking bench for vend_change_ctrl

module tb_vend_change_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] price = '0;
   logic         coin_valid = 1'b0;
   logic [W-1:0] coin_value = '0;
   logic         coin_ready;
   logic         cancel = 1'b0;
   logic         soda;
   logic [W-1:0] total;
   logic         hopper_req;
   logic [1:0]   hopper_coin;
   logic         hopper_ack = 1'b0;
   logic         busy;
   logic         done;

   int checks   = 0;
   int failures = 0;

   int soda_cnt = 0;
   int done_cnt = 0;
   int coin_n   = 0;
   int coin_log [0:255];
   logic req_prev = 1'b0;
   logic ack_en   = 1'b1;

   vend_change_ctrl #(.W(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .price       (price),
      .coin_valid  (coin_valid),
      .coin_value  (coin_value),
      .coin_ready  (coin_ready),
      .cancel      (cancel),
      .soda        (soda),
      .total       (total),
      .hopper_req  (hopper_req),
      .hopper_coin (hopper_coin),
      .hopper_ack  (hopper_ack),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   // Pulse monitor and hopper model, sampled 1ns after each rising edge.
   always @(posedge clk) begin
      #1;
      if (soda) soda_cnt = soda_cnt + 1;
      if (done) done_cnt = done_cnt + 1;
      if (hopper_req && !req_prev && coin_n < 256) begin
         coin_log[coin_n] = int'(hopper_coin);
         coin_n = coin_n + 1;
      end
      req_prev = hopper_req;
      hopper_ack = ack_en && hopper_req && !hopper_ack;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         failures = failures + 1;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic do_start(input logic [W-1:0] p);
      start = 1'b1;
      price = p;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic insert(input logic [W-1:0] v);
      coin_valid = 1'b1;
      coin_value = v;
      @(negedge clk);
      coin_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int base);
      int seen = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done_cnt != base) begin
            seen = 1;
            break;
         end
      end
      check_eq(tag, seen, 1);
      @(negedge clk);
   endtask

   // exp_packed lists expected denomination codes, first coin in bits [1:0].
   task automatic check_coins(input string tag, input int base, input int exp_n,
                              input logic [31:0] exp_packed);
      logic [31:0] e;
      e = exp_packed;
      check_eq({tag, "_count"}, coin_n - base, exp_n);
      for (int i = 0; i < exp_n; i++) begin
         check_eq({tag, "_coin"}, coin_log[(base + i) % 256], {30'd0, e[1:0]});
         e = e >> 2;
      end
   endtask

   initial begin
      int sb, db, cb;

      #3;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_ready", coin_ready, 0);
      check_eq("rst_total", total, 0);
      check_eq("rst_hreq", hopper_req, 0);
      check_eq("rst_hcoin", hopper_coin, 0);
      check_eq("rst_soda_done", {soda, done}, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Exact price: 75 with three quarters.
      sb = soda_cnt; db = done_cnt; cb = coin_n;
      do_start(8'd75);
      check_eq("t35_ready", coin_ready, 1);
      check_eq("t35_busy", busy, 1);
      insert(8'd25); insert(8'd25); insert(8'd25);
      check_eq("t35_total", total, 75);
      check_eq("t35_soda_early", soda, 0);
      @(negedge clk);
      check_eq("t35_soda", soda, 1);
      wait_done("t35_done", db);
      check_eq("t35_soda_cnt", soda_cnt - sb, 1);
      check_coins("t35", cb, 0, 0);
      check_eq("t35_total_hold", total, 75);
      check_eq("t35_idle", busy, 0);

      // Change 15 -> 10c then 5c; a start during COLLECT must be ignored.
      sb = soda_cnt; db = done_cnt; cb = coin_n;
      do_start(8'd60);
      insert(8'd25);
      start = 1'b1; price = 8'd0;
      @(negedge clk);
      start = 1'b0;
      check_eq("t36_ign_start", total, 25);
      insert(8'd25); insert(8'd25);
      wait_done("t36_done", db);
      check_eq("t36_soda_cnt", soda_cnt - sb, 1);
      check_coins("t36", cb, 2, 32'h6);

`ifdef VEND_CANCEL_EN
      sb = soda_cnt; db = done_cnt; cb = coin_n;
      do_start(8'd50);
      insert(8'd25); insert(8'd10);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      wait_done("t37_done", db);
      check_eq("t37_soda_cnt", soda_cnt - sb, 0);
      check_coins("t37", cb, 2, 32'hB);
`else
      // Cancel has no effect without the refund build.
      sb = soda_cnt; db = done_cnt; cb = coin_n;
      do_start(8'd50);
      insert(8'd25);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      insert(8'd25);
      wait_done("t37_done", db);
      check_eq("t37_soda_cnt", soda_cnt - sb, 1);
      check_coins("t37", cb, 0, 0);
`endif

      // Saturation at 255.
      sb = soda_cnt; db = done_cnt; cb = coin_n;
      do_start(8'd255);
      insert(8'd200); insert(8'd100);
      check_eq("t38_total", total, 255);
      wait_done("t38_done", db);
      check_eq("t38_soda_cnt", soda_cnt - sb, 1);
      check_coins("t38", cb, 0, 0);

      // Zero price vends without coins.
      sb = soda_cnt; db = done_cnt; cb = coin_n;
      do_start(8'd0);
      check_eq("t39_ready", coin_ready, 1);
      check_eq("t39_soda_early", soda, 0);
      @(negedge clk);
      check_eq("t39_soda", soda, 1);
      wait_done("t39_done", db);
      check_coins("t39", cb, 0, 0);

      // Largest greedy case: change 199 = 7x25 + 2x10 + 4x1.
      db = done_cnt; cb = coin_n;
      do_start(8'd1);
      insert(8'd200);
      wait_done("t27_done", db);
      check_coins("t27", cb, 13, 32'h2BFFF);

      // Reset in WAIT_ACK aborts the payout asynchronously.
      ack_en = 1'b0;
      cb = coin_n;
      do_start(8'd30);
      insert(8'd50);
      begin
         int seen = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (hopper_req) begin
               seen = 1;
               break;
            end
         end
         check_eq("t40_req_seen", seen, 1);
      end
      check_eq("t40_coin", hopper_coin, 2);
      #2 rst = 1'b1;
      #1;
      check_eq("t40_req_drop", hopper_req, 0);
      check_eq("t40_busy_drop", busy, 0);
      check_eq("t40_total", total, 0);
      @(negedge clk);
      rst = 1'b0;
      ack_en = 1'b1;
      @(negedge clk);
      sb = soda_cnt; db = done_cnt; cb = coin_n;
      do_start(8'd10);
      insert(8'd10);
      wait_done("t40_after_done", db);
      check_eq("t40_after_soda", soda_cnt - sb, 1);
      check_coins("t40_after", cb, 0, 0);
      check_eq("t40_after_total", total, 10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vend_change_ctrl.md
VEND_CHANGE_CTRL -- requirements
Module: vend_change_ctrl

Interface
REQ-001 SHALL have parameter W, default 8: width of price, coin, total and change values, in cents.
REQ-002 SHALL have port clk, input, 1: single clock, rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1: begin a transaction; honoured only in IDLE.
REQ-005 SHALL have port price, input, W: item price; sampled only on an accepted start.
REQ-006 SHALL have port coin_valid, input, 1: a coin is presented.
REQ-007 SHALL have port coin_value, input, W: value of the presented coin.
REQ-008 SHALL have port coin_ready, output, 1: a coin can be accepted this cycle.
REQ-009 SHALL have port cancel, input, 1: request a refund; active only when VEND_CANCEL_EN is defined.
REQ-010 SHALL have port soda, output, 1: one-cycle dispense pulse.
REQ-011 SHALL have port total, output, W: registered running coin total.
REQ-012 SHALL have port hopper_req, output, 1: change-coin request to the hopper.
REQ-013 SHALL have port hopper_coin, output, 2: coin denomination, where 0=1c, 1=5c, 2=10c, 3=25c.
REQ-014 SHALL have port hopper_ack, input, 1: hopper has paid out the requested coin.
REQ-015 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-016 SHALL have port done, output, 1: one-cycle transaction-complete pulse.

Function
REQ-017 SHALL implement states IDLE, COLLECT, VEND, PAYOUT, WAIT_ACK and DONE.
REQ-018 IDLE SHALL, on start, latch price into price_q, clear total to 0 and go to COLLECT; start SHALL be ignored in all other states.
REQ-019 coin_ready SHALL be 1 only in COLLECT; a coin SHALL be accepted on a clock edge where coin_valid and coin_ready are both 1.
REQ-020 On acceptance, total SHALL become total+coin_value, saturating at 2^W-1.
REQ-021 COLLECT SHALL go to VEND when the registered total >= price_q: a coin accepted at edge N reaches VEND at edge N+1; price_q=0 reaches VEND one cycle after COLLECT is entered.
REQ-022 VEND SHALL last one cycle with soda=1, load change <= total-price_q, then go to PAYOUT.
REQ-023 PAYOUT SHALL go to DONE if change=0; otherwise it SHALL register the largest denomination not exceeding change (25, 10, 5, then 1) onto hopper_coin, set hopper_req=1 and go to WAIT_ACK.
REQ-024 WAIT_ACK SHALL hold hopper_req and hopper_coin stable until hopper_ack; on hopper_ack it SHALL subtract the denomination from change, clear hopper_req and return to PAYOUT.
REQ-025 hopper_req SHALL therefore be low for at least one cycle between consecutive coins; hopper_ack outside WAIT_ACK SHALL be ignored.
REQ-026 DONE SHALL pulse done for one cycle, then go to IDLE; total SHALL hold its value until the next accepted start.
REQ-027 Change payout SHALL be exact for every change value from 0 to 2^W-1.
REQ-028 The controller SHALL never use an unreachable-state encoding; any illegal state SHALL return to IDLE on the next edge.

Reset
REQ-029 rst SHALL immediately force state=IDLE, total=0, change=0, price_q=0, and coin_ready, soda, hopper_req, hopper_coin, busy and done all to 0.
REQ-030 rst asserted mid-transaction, including in WAIT_ACK, SHALL abort it; hopper_req SHALL drop without waiting for the clock, and unpaid change SHALL be discarded.

Configuration
REQ-031 With macro VEND_CANCEL_EN defined, cancel=1 in COLLECT SHALL load change <= total and go to PAYOUT with no soda pulse.
REQ-032 With VEND_CANCEL_EN defined, a coin accepted in the same cycle as cancel SHALL be included in the refund, and cancel SHALL take priority over the total>=price_q transition.
REQ-033 With VEND_CANCEL_EN defined, cancel in any state other than COLLECT SHALL be ignored.
REQ-034 With VEND_CANCEL_EN undefined, the cancel port SHALL exist but be ignored, and no refund logic SHALL be synthesised.

Verification
REQ-035 price=75, coins 25,25,25 -> soda pulse one cycle after third coin, no hopper_req, done pulse, total=75.
REQ-036 price=60, coins 25,25,25 -> soda pulse, then hopper_coin=2 (10c) acked, then hopper_coin=1 (5c) acked, then done.
REQ-037 VEND_CANCEL_EN defined, price=50, coins 25,10, then cancel -> no soda pulse; refund of hopper_coin=3 then 2; done.
REQ-038 W=8, price=255, coins 200 then 100 -> total saturates at 255, soda pulse, no payout.
REQ-039 price=0, start -> soda pulse with no coins, change=0, done.
REQ-040 price=30, coin 50, rst pulsed during the first WAIT_ACK -> hopper_req and busy drop immediately, total=0, subsequent start works normally.
